// File: rtl/sprite_mem_pkg.sv
// rtl/sprite_mem_pkg.sv - shared sprite memory geometry constants and writer FSM state type
package sprite_mem_pkg;

    localparam int SPRITE_SIZE      = 20;
    localparam int SPRITE_PIXELS    = 400;
    localparam int ADDR_BG          = 16383;
    localparam int DEFAULT_MAX_SLOT = 39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } writer_state_t;

endpackage

// File: rtl/sprite_pixel_counter.sv
// rtl/sprite_pixel_counter.sv - col/line position counter over one 20x20 sprite, row-major
module sprite_pixel_counter
    import sprite_mem_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] col,
    output logic [4:0] line,
    output logic       last
);

    localparam logic [4:0] EDGE = 5'(SPRITE_SIZE - 1);

    // advance col each enabled cycle; wrapping col steps line
    always_ff @(posedge clk_pixel) begin
        if (reset || clear) begin
            col  <= '0;
            line <= '0;
        end else if (enable) begin
            if (col == EDGE) begin
                col  <= '0;
                line <= (line == EDGE) ? '0 : line + 5'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

    assign last = (line == EDGE) && (col == EDGE);

endmodule

// File: rtl/sprite_memory_writer.sv
// rtl/sprite_memory_writer.sv - loads 400-pixel sprites into sprite RAM (optional SPRITE_WRITE_BLANK_EN)
module sprite_memory_writer
    import sprite_mem_pkg::*;
#(
    parameter int DATA_W       = 9,
    parameter int SIZE_ADDRESS = 14,
    parameter int MAX_SLOT     = sprite_mem_pkg::DEFAULT_MAX_SLOT
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [8:0]              cmd_slot,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [DATA_W-1:0]       pix_data,
    input  logic                    abort,
`ifdef SPRITE_WRITE_BLANK_EN
    input  logic                    video_active,
`endif
    output logic                    mem_we,
    output logic [SIZE_ADDRESS-1:0] mem_address,
    output logic [DATA_W-1:0]       mem_data,
    output logic                    load_done,
    output logic                    load_error
);

    localparam logic [SIZE_ADDRESS-1:0] BG_ADDR = SIZE_ADDRESS'(ADDR_BG);

    writer_state_t          state_q, state_d;
    logic                   cmd_accept;
    logic                   pix_accept;
    logic                   cnt_clear;
    logic                   slot_illegal;
    logic                   blank_hold;
    logic [SIZE_ADDRESS-1:0] slot_base;
    logic [SIZE_ADDRESS-1:0] base_q;
    logic [SIZE_ADDRESS-1:0] pix_addr;
    logic [4:0]             col;
    logic [4:0]             line;
    logic                   last;

`ifdef SPRITE_WRITE_BLANK_EN
    // RAM port belongs to the display during active video
    assign blank_hold = video_active;
`else
    assign blank_hold = 1'b0;
`endif

    assign slot_illegal = cmd_slot > 9'(MAX_SLOT);
    assign slot_base    = SIZE_ADDRESS'(cmd_slot) * SIZE_ADDRESS'(SPRITE_PIXELS);
    assign pix_addr     = base_q
                        + SIZE_ADDRESS'(line) * SIZE_ADDRESS'(SPRITE_SIZE)
                        + SIZE_ADDRESS'(col);

    sprite_pixel_counter u_counter (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (cnt_clear),
        .enable    (pix_accept),
        .col       (col),
        .line      (line),
        .last      (last)
    );

    // FSM state register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        pix_ready  = 1'b0;
        cmd_accept = 1'b0;
        pix_accept = 1'b0;
        cnt_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready  = !reset;
                cmd_accept = cmd_valid && cmd_ready;
                cnt_clear  = 1'b1;
                if (cmd_accept && !slot_illegal) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pix_ready  = !abort && !reset && !blank_hold;
                pix_accept = pix_valid && pix_ready;
                if (abort) begin
                    state_d = IDLE;
                end else if (pix_accept && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // registered RAM write port, base latch and status pulses
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_address <= BG_ADDR;
            mem_data    <= '0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            base_q      <= '0;
        end else begin
            mem_we     <= pix_accept;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            if (pix_accept) begin
                mem_address <= pix_addr;
                mem_data    <= pix_data;
            end
            if (cmd_accept) begin
                if (slot_illegal) begin
                    load_error <= 1'b1;
                end else begin
                    base_q <= slot_base;
                end
            end
            if (state_q == DONE) begin
                load_done   <= 1'b1;
                mem_address <= BG_ADDR;
            end
            if (state_q == LOAD && abort) begin
                mem_address <= BG_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_sprite_memory_writer.sv
// tb/tb_sprite_memory_writer.sv - directed self-checking bench for sprite_memory_writer
module tb_sprite_memory_writer;

    localparam int DATA_W       = 9;
    localparam int SIZE_ADDRESS = 14;
    localparam int BG           = 16383;

    logic                    clk_pixel = 1'b0;
    logic                    reset     = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [8:0]              cmd_slot  = '0;
    logic                    pix_valid = 1'b0;
    logic                    pix_ready;
    logic [DATA_W-1:0]       pix_data  = '0;
    logic                    abort     = 1'b0;
`ifdef SPRITE_WRITE_BLANK_EN
    logic                    video_active = 1'b0;
    bit                      blank_mode   = 1'b0;
`endif
    logic                    mem_we;
    logic [SIZE_ADDRESS-1:0] mem_address;
    logic [DATA_W-1:0]       mem_data;
    logic                    load_done;
    logic                    load_error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sprite_memory_writer #(
        .DATA_W       (DATA_W),
        .SIZE_ADDRESS (SIZE_ADDRESS),
        .MAX_SLOT     (39)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_slot     (cmd_slot),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .abort        (abort),
`ifdef SPRITE_WRITE_BLANK_EN
        .video_active (video_active),
`endif
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_pixel);
        #1;
        cyc++;
    endtask

    task automatic send_cmd(input logic [8:0] slot);
        cmd_valid = 1'b1;
        cmd_slot  = slot;
        @(negedge clk_pixel);
        chk("cmd_ready_idle", cmd_ready, 1);
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic send_pixels(input int slot, input int count, input bit gaps, input int pattern);
        int   k        = 0;
        int   budget   = 0;
        bit   prev_acc = 1'b0;
        bit   ready_exp;
        int   exp_addr = 0;
        logic [DATA_W-1:0] exp_data = '0;
        while (k < count && budget < 4000) begin
            pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_data  = DATA_W'(k ^ pattern);
            cmd_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b0;
            cmd_slot  = 9'd3;
            ready_exp = 1'b1;
`ifdef SPRITE_WRITE_BLANK_EN
            if (blank_mode) begin
                video_active = ((cyc / 10) % 2) == 1;
                ready_exp    = !video_active;
            end
`endif
            @(negedge clk_pixel);
            chk("pix_ready_load", pix_ready, ready_exp);
            chk("cmd_ready_load", cmd_ready, 0);
            chk("mem_we_load", mem_we, prev_acc);
            if (prev_acc) begin
                chk("mem_address_load", mem_address, exp_addr);
                chk("mem_data_load", mem_data, exp_data);
            end
            prev_acc = pix_valid && ready_exp;
            if (prev_acc) begin
                exp_addr = slot * 400 + k;
                exp_data = pix_data;
                k++;
            end
            next_cycle();
            budget++;
        end
        pix_valid = 1'b0;
        cmd_valid = 1'b0;
`ifdef SPRITE_WRITE_BLANK_EN
        video_active = 1'b0;
`endif
        chk("pix_count", k, count);
        @(negedge clk_pixel);
        chk("mem_we_final", mem_we, 1);
        chk("mem_address_final", mem_address, exp_addr);
        chk("mem_data_final", mem_data, exp_data);
        chk("load_done_early", load_done, 0);
        next_cycle();
    endtask

    task automatic check_done();
        @(negedge clk_pixel);
        chk("load_done_pulse", load_done, 1);
        chk("mem_we_after_done", mem_we, 0);
        chk("mem_address_bg_done", mem_address, BG);
        chk("cmd_ready_after_done", cmd_ready, 1);
        next_cycle();
        @(negedge clk_pixel);
        chk("load_done_single", load_done, 0);
        next_cycle();
    endtask

    initial begin
        // reset state
        next_cycle();
        next_cycle();
        @(negedge clk_pixel);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_address", mem_address, BG);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_error", load_error, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk_pixel);
        chk("idle_cmd_ready", cmd_ready, 1);
        next_cycle();

        // slot 0, contiguous stream, data = index
        send_cmd(9'd0);
        send_pixels(0, 400, 1'b0, 0);
        check_done();

        // illegal slot 40
        send_cmd(9'd40);
        @(negedge clk_pixel);
        chk("load_error_pulse", load_error, 1);
        chk("mem_we_bad_slot", mem_we, 0);
        chk("cmd_ready_bad_slot", cmd_ready, 1);
        chk("mem_address_bad_slot", mem_address, BG);
        next_cycle();
        @(negedge clk_pixel);
        chk("load_error_single", load_error, 0);
        next_cycle();

        // slot 39 with random gaps and stray commands
        send_cmd(9'd39);
        send_pixels(39, 400, 1'b1, 9'h155);
        check_done();

        // slot 2 aborted after 25 pixels
        send_cmd(9'd2);
        send_pixels(2, 25, 1'b0, 9'h0f0);
        abort     = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk_pixel);
        chk("pix_ready_abort", pix_ready, 0);
        chk("mem_we_abort", mem_we, 0);
        next_cycle();
        abort     = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk_pixel);
        chk("mem_we_post_abort", mem_we, 0);
        chk("mem_address_post_abort", mem_address, BG);
        chk("load_done_abort", load_done, 0);
        chk("cmd_ready_post_abort", cmd_ready, 1);
        next_cycle();
        send_cmd(9'd2);
        send_pixels(2, 3, 1'b0, 0);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;

        // reset in the middle of slot 5
        send_cmd(9'd5);
        send_pixels(5, 100, 1'b0, 9'h1ff);
        reset     = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk_pixel);
        chk("pix_ready_in_reset", pix_ready, 0);
        next_cycle();
        @(negedge clk_pixel);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_address", mem_address, BG);
        chk("midrst_mem_data", mem_data, 0);
        chk("midrst_load_done", load_done, 0);
        chk("midrst_load_error", load_error, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pixel);
            chk("post_rst_mem_we", mem_we, 0);
            chk("post_rst_pix_ready", pix_ready, 0);
            next_cycle();
        end
        pix_valid = 1'b0;

`ifdef SPRITE_WRITE_BLANK_EN
        // writes only during blanking
        blank_mode = 1'b1;
        send_cmd(9'd7);
        send_pixels(7, 400, 1'b1, 9'h0aa);
        check_done();
        blank_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
